// File: rtl/imem_port_arbiter.sv
// Byte-wide memory port arbiter between instruction fetch and the memory stage.
// Data accesses are split into little-endian byte beats while fetch is stalled.
module imem_port_arbiter #(
    parameter int AW       = 32,
    parameter int FAIR_GAP = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] f_addr,
    output logic [7:0]    f_rdata,
    output logic          f_grant,
    input  logic          m_req,
    input  logic          m_we,
    input  logic [1:0]    m_size,
    input  logic          m_signed,
    input  logic [AW-1:0] m_addr,
    input  logic [31:0]   m_wdata,
    output logic [31:0]   m_rdata,
    output logic          m_done,
    output logic          m_busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int GW = (FAIR_GAP > 1) ? $clog2(FAIR_GAP) : 1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          we_q;
    logic          signed_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   m_rdata_q, m_rdata_d;
    logic          done_q, done_d;
    logic          last_beat;
    logic [31:0]   rd_full;

    function automatic logic [31:0] extend(
        input logic [31:0] v,
        input logic [1:0]  sz,
        input logic        sg
    );
        case (sz)
            2'b00:   return {{24{sg & v[7]}}, v[7:0]};
            2'b01:   return {{16{sg & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Final beat index depends on access size (1, 2 or 4 beats).
    always_comb begin
        case (size_q)
            2'b00:   last_beat = (cnt_q == 2'd0);
            2'b01:   last_beat = (cnt_q == 2'd1);
            default: last_beat = (cnt_q == 2'd3);
        endcase
    end

    // Next-state and port steering; fetch owns the port outside XFER.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        m_rdata_d = m_rdata_q;
        f_grant   = 1'b1;
        mem_addr  = f_addr;
        mem_we    = 1'b0;
        mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        rd_full   = rdata_q;
        rd_full[{cnt_q, 3'b000} +: 8] = mem_rdata;
        case (state_q)
            IDLE: begin
                if (m_req) begin
                    state_d = XFER;
                    cnt_d   = 2'd0;
                end
            end
            XFER: begin
                f_grant  = 1'b0;
                mem_addr = addr_q + AW'(cnt_q);
                mem_we   = we_q;
                cnt_d    = cnt_q + 2'd1;
                if (!we_q) begin
                    rdata_d = rd_full;
                end
                if (last_beat) begin
                    state_d = DONE;
                    gap_d   = GW'(FAIR_GAP - 1);
                    done_d  = 1'b1;
                    if (!we_q) begin
                        m_rdata_d = extend(rd_full, size_q, signed_q);
                    end
                end
            end
            DONE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and load result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            gap_q     <= '0;
            rdata_q   <= 32'd0;
            m_rdata_q <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            rdata_q   <= rdata_d;
            m_rdata_q <= m_rdata_d;
            done_q    <= done_d;
        end
    end

    // Capture the request attributes in the IDLE cycle that accepts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= '0;
            size_q   <= 2'd0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= 32'd0;
        end else if (state_q == IDLE && m_req) begin
            addr_q   <= m_addr;
            size_q   <= m_size;
            we_q     <= m_we;
            signed_q <= m_signed;
            wdata_q  <= m_wdata;
        end
    end

    assign f_rdata = mem_rdata;
    assign m_rdata = m_rdata_q;
    assign m_done  = done_q;
    assign m_busy  = (state_q == XFER) || (state_q == DONE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small combinational byte memory.
// A second instance with a wider fairness gap covers back-to-back requests.
module tb_imem_port_arbiter;

    logic        clk;
    logic        resetn;
    logic [31:0] f_addr;
    logic [7:0]  f_rdata;
    logic        f_grant;
    logic        m_req;
    logic        m_we;
    logic [1:0]  m_size;
    logic        m_signed;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_done;
    logic        m_busy;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        m_req2;
    logic [7:0]  f_rdata2;
    logic        f_grant2;
    logic [31:0] m_rdata2;
    logic        m_done2;
    logic        m_busy2;
    logic [31:0] mem_addr2;
    logic        mem_we2;
    logic [7:0]  mem_wdata2;
    logic [7:0]  mem_rdata2;

    logic [7:0]  mem [0:4095];

    int total;
    int bad;

    assign mem_rdata  = mem[mem_addr[11:0]];
    assign mem_rdata2 = 8'h5A;

    imem_port_arbiter #(.AW(32), .FAIR_GAP(1)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .f_addr    (f_addr),
        .f_rdata   (f_rdata),
        .f_grant   (f_grant),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_size    (m_size),
        .m_signed  (m_signed),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_done    (m_done),
        .m_busy    (m_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    imem_port_arbiter #(.AW(32), .FAIR_GAP(2)) u_dut2 (
        .clk       (clk),
        .resetn    (resetn),
        .f_addr    (32'h0000_0040),
        .f_rdata   (f_rdata2),
        .f_grant   (f_grant2),
        .m_req     (m_req2),
        .m_we      (1'b0),
        .m_size    (2'b00),
        .m_signed  (1'b0),
        .m_addr    (32'h0000_0080),
        .m_wdata   (32'h0),
        .m_rdata   (m_rdata2),
        .m_done    (m_done2),
        .m_busy    (m_busy2),
        .mem_addr  (mem_addr2),
        .mem_we    (mem_we2),
        .mem_wdata (mem_wdata2),
        .mem_rdata (mem_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one access from IDLE and check every beat plus the done cycle.
    task automatic access(
        input logic        we,
        input logic [1:0]  sz,
        input logic        sg,
        input logic [31:0] a,
        input logic [31:0] wd
    );
        int n;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        m_req    = 1'b1;
        m_we     = we;
        m_size   = sz;
        m_signed = sg;
        m_addr   = a;
        m_wdata  = wd;
        #1;
        chk("latch_grant", f_grant, 1);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            chk("xfer_grant", f_grant, 0);
            chk("xfer_addr", mem_addr, a + b);
            chk("xfer_we", mem_we, we);
            if (we) chk("xfer_wdata", mem_wdata, wd[8*b +: 8]);
            chk("xfer_nodone", m_done, 0);
        end
        @(negedge clk);
        chk("done_pulse", m_done, 1);
        chk("done_grant", f_grant, 1);
        chk("done_we", mem_we, 0);
        m_req = 1'b0;
    endtask

    initial begin
        logic [7:0]  exp_b [0:3];
        logic [5:0]  g_exp;
        logic [5:0]  d_exp;
        logic [5:0]  b_exp;
        logic        seen_we;
        logic        seen_done;
        total    = 0;
        bad      = 0;
        resetn   = 1'b0;
        f_addr   = 32'h100;
        m_req    = 1'b0;
        m_req2   = 1'b0;
        m_we     = 1'b0;
        m_size   = 2'b00;
        m_signed = 1'b0;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h11;
        mem[12'h101] = 8'h22;
        mem[12'h102] = 8'h33;
        mem[12'h103] = 8'h44;
        mem[12'h200] = 8'h78;
        mem[12'h201] = 8'h56;
        mem[12'h202] = 8'h34;
        mem[12'h203] = 8'h12;
        mem[12'h500] = 8'h80;
        mem[12'h501] = 8'h90;
        exp_b[0] = 8'h11;
        exp_b[1] = 8'h22;
        exp_b[2] = 8'h33;
        exp_b[3] = 8'h44;

        repeat (2) @(negedge clk);
        chk("rst_grant", f_grant, 1);
        chk("rst_done", m_done, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", m_busy, 0);
        resetn = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            f_addr = 32'h100 + i;
            #1;
            chk("idle_grant", f_grant, 1);
            chk("idle_rdata", f_rdata, exp_b[i]);
            chk("idle_we", mem_we, 0);
        end

        @(negedge clk);
        access(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        chk("ld_word", m_rdata, 32'h12345678);
        @(negedge clk);
        chk("post_done", m_done, 0);
        chk("post_busy", m_busy, 0);
        chk("ld_hold", m_rdata, 32'h12345678);

        access(1'b1, 2'b01, 1'b0, 32'h3FF, 32'hAABBCCDD);
        chk("st_keep", m_rdata, 32'h12345678);
        @(negedge clk);
        chk("st_idle_we", mem_we, 0);

        access(1'b0, 2'b00, 1'b1, 32'h500, 32'h0);
        chk("ld_b_sx", m_rdata, 32'hFFFFFF80);
        @(negedge clk);
        access(1'b0, 2'b00, 1'b0, 32'h500, 32'h0);
        chk("ld_b_zx", m_rdata, 32'h00000080);
        @(negedge clk);
        access(1'b0, 2'b01, 1'b1, 32'h500, 32'h0);
        chk("ld_h_sx", m_rdata, 32'hFFFF9080);
        @(negedge clk);

        access(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h01020304);
        @(negedge clk);

        m_req   = 1'b1;
        m_we    = 1'b1;
        m_size  = 2'b10;
        m_addr  = 32'h600;
        m_wdata = 32'h11223344;
        @(negedge clk);
        @(negedge clk);
        chk("mid_we", mem_we, 1);
        chk("mid_addr", mem_addr, 32'h601);
        resetn = 1'b0;
        #1;
        chk("mid_rst_grant", f_grant, 1);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_busy", m_busy, 0);
        chk("mid_rst_done", m_done, 0);
        m_req = 1'b0;
        @(negedge clk);
        resetn    = 1'b1;
        seen_we   = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_we   = seen_we | mem_we;
            seen_done = seen_done | m_done;
        end
        chk("rst_no_we", seen_we, 0);
        chk("rst_no_done", seen_done, 0);
        chk("rst_rdata0", m_rdata, 0);

        g_exp  = 6'b011101;
        d_exp  = 6'b000100;
        b_exp  = 6'b101110;
        m_req2 = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk("gap_grant", f_grant2, g_exp[c]);
            chk("gap_done", m_done2, d_exp[c]);
            chk("gap_busy", m_busy2, b_exp[c]);
            @(negedge clk);
        end
        m_req2 = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
